// File: rtl/minmax_window_ctrl.sv
// Window sequencer for the min/max averaging datapath: splits a valid/ready
// sample stream into win_len windows and captures one average per window.
module minmax_window_ctrl #(
    parameter int MSB  = 8,
    parameter int CNTW = 8
) (
    input  logic            clock,
    input  logic            clear,
    input  logic            run,
    input  logic [CNTW-1:0] win_len,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [MSB:0]    in_data,
    output logic            dp_clear,
    output logic            dp_enable,
    output logic            dp_reset,
    output logic [MSB:0]    dp_in,
    input  logic [MSB:0]    dp_out,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [MSB:0]    res_data,
    output logic [7:0]      res_seq,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, START, ACCUM} state_t;

    typedef struct packed {
        logic [MSB:0] data;
        logic [7:0]   seq;
    } res_t;

    state_t          state;
    logic [CNTW-1:0] rem;
    logic [MSB:0]    hold;
    res_t            res;
    logic            accept;
    logic            done;

    // The result slot is checked combinationally so a drain and a new accept
    // can share a cycle.
    assign in_ready = run && (state != IDLE) && (!res_valid || res_ready);
    assign accept   = in_valid && in_ready;
    assign done     = accept &&
                      (((state == START) && (win_len == CNTW'(1))) ||
                       ((state == ACCUM) && (rem == CNTW'(1))));

    assign dp_clear  = clear;
    // Enable stays high through ACCUM stalls (replaying hold), since dropping
    // it would wipe the window's min/max.
    assign dp_enable = accept || (state == ACCUM);
    assign dp_reset  = accept && (state == START);
    assign dp_in     = accept ? in_data : hold;
    assign busy      = (state == ACCUM);
    assign res_data  = res.data;
    assign res_seq   = res.seq;

    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= IDLE;
            rem       <= '0;
            hold      <= '0;
            res       <= '0;
            res_valid <= 1'b0;
        end else begin
            if (accept)
                hold <= in_data;

            if (done) begin
                res.data  <= dp_out;
                res.seq   <= res.seq + 8'd1;
                res_valid <= 1'b1;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (run)
                        state <= START;
                end
                START: begin
                    if (!run) begin
                        state <= IDLE;
                    end else if (accept) begin
                        rem <= win_len - CNTW'(1);
                        if (win_len != CNTW'(1))
                            state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (!run) begin
                        state <= IDLE;
                    end else if (accept) begin
                        rem <= rem - CNTW'(1);
                        if (rem == CNTW'(1))
                            state <= START;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_minmax_window_ctrl.sv
// Bench for minmax_window_ctrl: directed vector table, corner sequences and
// random traffic against a window-level reference model.
module tb_minmax_window_ctrl;
    localparam int MSB  = 8;
    localparam int CNTW = 8;

    logic            clock = 1'b0;
    logic            clear, run, in_valid, res_ready;
    logic [CNTW-1:0] win_len;
    logic [MSB:0]    in_data;
    logic            in_ready, dp_clear, dp_enable, dp_reset, res_valid, busy;
    logic [MSB:0]    dp_in, dp_out, res_data;
    logic [7:0]      res_seq;

    int n_chk  = 0;
    int n_fail = 0;

    minmax_window_ctrl #(.MSB(MSB), .CNTW(CNTW)) dut (
        .clock(clock), .clear(clear), .run(run), .win_len(win_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .dp_clear(dp_clear), .dp_enable(dp_enable), .dp_reset(dp_reset),
        .dp_in(dp_in), .dp_out(dp_out), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_seq(res_seq),
        .busy(busy)
    );

    always #5 clock = ~clock;

    // External datapath: combinational average over the window seen so far,
    // including the sample presented this cycle.
    logic [MSB:0]   dmin, dmax, cmin, cmax;
    logic           dempty = 1'b1;
    logic [MSB+1:0] dsum;
    always_comb begin
        cmin = dp_in;
        cmax = dp_in;
        if (!dp_reset && !dempty) begin
            cmin = (dmin < dp_in) ? dmin : dp_in;
            cmax = (dmax > dp_in) ? dmax : dp_in;
        end
        dsum = {1'b0, cmin} + {1'b0, cmax};
    end
    assign dp_out = dsum[MSB+1:1];
    always @(posedge clock) begin
        if (dp_clear || !dp_enable) begin
            dempty <= 1'b1;
        end else begin
            dmin   <= cmin;
            dmax   <= cmax;
            dempty <= 1'b0;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: accepted samples grouped into windows; each full
    // window yields floor((min+max)/2) and the next sequence number.
    typedef struct { int data; int seq; } exp_t;
    int   win_q[$];
    exp_t exp_q[$];
    int   cur_len, exp_seq = 0, last_acc = 0;
    bit   m_acc;

    function automatic int win_avg();
        int mn = 1 << 30, mx = -1;
        foreach (win_q[i]) begin
            if (win_q[i] < mn) mn = win_q[i];
            if (win_q[i] > mx) mx = win_q[i];
        end
        return (mn + mx) / 2;
    endfunction

    always @(negedge clock) begin
        if (clear) begin
            win_q.delete();
            exp_q.delete();
            exp_seq  = 0;
            last_acc = 0;
        end else begin
            m_acc = in_valid && in_ready;
            if (!run || (res_valid && !res_ready))
                chk("m_in_ready_blocked", int'(in_ready), 0);
            chk("m_busy", int'(busy), int'(win_q.size() > 0));
            if (m_acc) begin
                chk("m_acc_enable", int'(dp_enable), 1);
                chk("m_acc_dp_in", int'(dp_in), int'(in_data));
                chk("m_acc_dp_reset", int'(dp_reset), int'(win_q.size() == 0));
            end else if (win_q.size() > 0) begin
                chk("m_stall_enable", int'(dp_enable), 1);
                chk("m_stall_hold", int'(dp_in), last_acc);
                chk("m_stall_dp_reset", int'(dp_reset), 0);
            end else begin
                chk("m_idle_enable", int'(dp_enable), 0);
            end
            if (res_valid && res_ready) begin
                chk("m_res_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    chk("m_res_data", int'(res_data), exp_q[0].data);
                    chk("m_res_seq", int'(res_seq), exp_q[0].seq);
                    void'(exp_q.pop_front());
                end
            end
            if (!run) begin
                win_q.delete();
            end else if (m_acc) begin
                if (win_q.size() == 0)
                    cur_len = (win_len == 0) ? (1 << CNTW) : int'(win_len);
                win_q.push_back(int'(in_data));
                last_acc = int'(in_data);
                if (win_q.size() == cur_len) begin
                    exp_seq = (exp_seq + 1) % 256;
                    exp_q.push_back('{win_avg(), exp_seq});
                    win_q.delete();
                end
            end
        end
    end

    // Tasks start and end at posedge+1.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [MSB:0] d);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clock);
            ok = in_ready;
            step();
        end
        in_valid = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic chk_res(input string nm, input int d, input int s);
        @(negedge clock);
        chk({nm, "_valid"}, int'(res_valid), 1);
        chk({nm, "_data"}, int'(res_data), d);
        chk({nm, "_seq"}, int'(res_seq), s);
        step();
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_in_ready"}, int'(in_ready), 0);
        chk({nm, "_dp_enable"}, int'(dp_enable), 0);
        chk({nm, "_dp_reset"}, int'(dp_reset), 0);
        chk({nm, "_dp_in"}, int'(dp_in), 0);
        chk({nm, "_res_valid"}, int'(res_valid), 0);
        chk({nm, "_res_data"}, int'(res_data), 0);
        chk({nm, "_res_seq"}, int'(res_seq), 0);
        chk({nm, "_busy"}, int'(busy), 0);
    endtask

    typedef struct {
        int len;
        int cnt;
        int s[4];
        int gap;
        int exp;
    } vec_t;

    function automatic vec_t mk(int len, int cnt, int s0, int s1, int s2,
                                int s3, int gap, int exp);
        vec_t v;
        v.len = len; v.cnt = cnt; v.gap = gap; v.exp = exp;
        v.s[0] = s0; v.s[1] = s1; v.s[2] = s2; v.s[3] = s3;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        int   seq = 0;

        tbl[0] = mk(4, 4, 10, 200, 50, 30, 0, 105);
        tbl[1] = mk(4, 4, 10, 200, 50, 30, 3, 105);
        tbl[2] = mk(1, 1, 77, 0, 0, 0, 0, 77);
        tbl[3] = mk(1, 1, 3, 0, 0, 0, 0, 3);
        tbl[4] = mk(3, 3, 511, 0, 256, 0, 1, 255);
        tbl[5] = mk(2, 2, 4, 4, 0, 0, 0, 4);
        tbl[6] = mk(3, 3, 9, 300, 300, 0, 2, 154);

        clear = 1'b1; run = 1'b1; in_valid = 1'b1; in_data = 9'h55;
        res_ready = 1'b1; win_len = 8'd4;
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        chk_reset_vals("rst");
        chk("rst_dp_clear", int'(dp_clear), 1);
        step();
        clear = 1'b0; in_valid = 1'b0;
        @(negedge clock);
        chk("first_cycle_in_ready", int'(in_ready), 0);
        chk("first_cycle_dp_clear", int'(dp_clear), 0);
        step();
        @(negedge clock);
        chk("second_cycle_in_ready", int'(in_ready), 1);
        step();

        for (int t = 0; t < 7; t++) begin
            win_len = 8'(tbl[t].len);
            for (int k = 0; k < tbl[t].cnt; k++) begin
                send(9'(tbl[t].s[k]));
                if (k < tbl[t].cnt - 1) begin
                    for (int g = 0; g < tbl[t].gap; g++) begin
                        @(negedge clock);
                        chk("tbl_gap_enable", int'(dp_enable), 1);
                        chk("tbl_gap_hold", int'(dp_in), tbl[t].s[k]);
                        step();
                    end
                end
            end
            seq++;
            chk_res("tbl_res", tbl[t].exp, seq);
        end

        // Pending result blocks input; no sample is lost across the stall.
        win_len = 8'd2; res_ready = 1'b0;
        send(9'd3);
        send(9'd4);
        seq++;
        @(negedge clock);
        chk("bp_first_valid", int'(res_valid), 1);
        chk("bp_first_data", int'(res_data), 3);
        step();
        in_valid = 1'b1; in_data = 9'd500;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_held_valid", int'(res_valid), 1);
            step();
        end
        res_ready = 1'b1;
        send(9'd500);
        send(9'd510);
        seq++;
        chk_res("bp_second", 505, seq);

        // Aborted window produces nothing.
        win_len = 8'd4;
        send(9'd100);
        send(9'd20);
        run = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            chk("abort_no_res", int'(res_valid), 0);
            if (i == 1) chk("abort_idle_busy", int'(busy), 0);
            step();
        end
        run = 1'b1;
        for (int i = 8; i <= 11; i++) send(9'(i));
        seq++;
        chk_res("abort_res", 9, seq);

        // win_len 0 means a full 2^CNTW-sample window.
        win_len = 8'd0;
        for (int i = 0; i < 256; i++) begin
            send(9'(i));
            if (i == 100) begin
                @(negedge clock);
                chk("w256_busy", int'(busy), 1);
                chk("w256_no_res", int'(res_valid), 0);
                step();
            end
        end
        seq++;
        chk_res("w256_res", 127, seq);

        // Clear pulse mid-window.
        win_len = 8'd4;
        send(9'd1);
        send(9'd2);
        clear = 1'b1;
        @(negedge clock);
        chk("clr_dp_clear", int'(dp_clear), 1);
        step();
        clear = 1'b0;
        @(negedge clock);
        chk_reset_vals("clr");
        step();
        for (int i = 5; i <= 8; i++) send(9'(i));
        chk_res("clr_after_res", 6, 1);

        // Random traffic checked by the reference model.
        for (int c = 0; c < 1500; c++) begin
            clear     = ($urandom_range(0, 399) == 0);
            run       = ($urandom_range(0, 49) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 9'($urandom_range(0, 511));
            res_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 19) == 0)
                win_len = 8'($urandom_range(1, 5));
            step();
        end
        clear = 1'b0; run = 1'b1; in_valid = 1'b0; res_ready = 1'b1;
        repeat (4) step();
        chk("rand_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/minmax_window_ctrl.md
# minmax_window_ctrl

Windowed sequencer for the min/max averaging datapath (9-bit sample, combinational `out` = floor((min+max)/2)). It accepts a valid/ready sample stream and splits it into windows of `win_len` samples. It drives the datapath's `clear`/`enable`/`reset`/`in` controls so each window restarts min/max tracking, and captures the datapath average on the last sample into a valid/ready result port. It sits between the sample source and the result consumer; the datapath instance is external.

## Interface
- `MSB`, default 8: index of sample MSB; sample width is MSB+1.
- `CNTW`, default 8: width of the window-length field.

- `clock` in 1: single clock; all state updates on rising edge.
- `clear` in 1: synchronous, active-high reset.
- `run` in 1: level enable. Low aborts the current window and idles.
- `win_len` in CNTW: samples per window, sampled at window start. 0 means 2^CNTW.
- `in_valid` in 1: upstream sample valid.
- `in_ready` out 1: upstream ready; accept = `in_valid & in_ready`.
- `in_data` in MSB+1: sample.
- `dp_clear` out 1: datapath clear; equals `clear`.
- `dp_enable` out 1: datapath enable.
- `dp_reset` out 1: datapath window restart.
- `dp_in` out MSB+1: datapath sample input.
- `dp_out` in MSB+1: datapath combinational output.
- `res_valid` out 1: result valid.
- `res_ready` in 1: downstream ready.
- `res_data` out MSB+1: window average.
- `res_seq` out 8: window sequence number, wraps 255→0.
- `busy` out 1: window in progress (ACCUM state).

## Operation
- States: IDLE, START, ACCUM.
- IDLE:
  - `dp_enable`=0, `in_ready`=0.
  - Goes to START when `run`=1.
- `in_ready` = `run` & (state≠IDLE) & (!`res_valid` | `res_ready`). Result-slot space is checked combinationally, so a result can drain and a new sample be accepted in the same cycle.
- START, on accept:
  - `dp_enable`=1, `dp_reset`=1, `dp_in`=`in_data`.
  - `rem` ← `win_len`−1 (mod 2^CNTW).
  - If `win_len`=1, the window completes this cycle and the state stays START. Otherwise go to ACCUM.
- START, no accept: `dp_enable`=0. The datapath min/max is empty anyway.
- ACCUM, on accept:
  - `dp_enable`=1, `dp_reset`=0, `dp_in`=`in_data`.
  - If `rem`=1, the window completes and the state goes to START. Otherwise `rem` decrements.
- ACCUM, no accept (stall):
  - `dp_enable`=1, `dp_reset`=0, `dp_in`=`hold`, the last accepted sample.
  - Replaying the held sample is idempotent for min/max and `last`.
  - `dp_enable` is never dropped mid-window, because enable low wipes datapath min/max.
- `hold` ← `in_data` on every accept.
- Window completion:
  - `res_data` ← `dp_out` (same-cycle datapath average including the final sample).
  - `res_valid` ← 1, `res_seq` ← `res_seq`+1.
- `res_valid` clears on `res_valid & res_ready` unless a new completion occurs that same cycle. In that case it stays 1 with the new data.
- `run`=0 in START or ACCUM:
  - Next state IDLE; the partial window is discarded and produces no result.
  - A pending result is retained until taken.
- `clear` has priority over everything:
  - State IDLE; `rem`, `hold`, `res_data`, `res_seq` = 0; `res_valid`=0.
  - The datapath is cleared via `dp_clear`.

## Timing
- Reset values after `clear`: `in_ready`=0, `dp_enable`=0, `dp_reset`=0, `dp_in`=0, `res_valid`=0, `res_data`=0, `res_seq`=0, `busy`=0. `dp_clear` follows `clear` combinationally.
- Earliest accept is the second cycle after `clear` falls with `run`=1: one cycle IDLE→START.
- Result latency: `res_valid`=1 on the cycle after the final sample is accepted.
- Throughput: one sample per cycle, including back-to-back windows, when `res_ready`=1.
- A result not taken blocks input (`in_ready`=0) until `res_ready`. No samples are lost, and the datapath holds via replay.
- Arithmetic:
  - `rem` wraps modulo 2^CNTW; `win_len`=0 yields 2^CNTW samples.
  - The average is computed by the datapath, floor of (min+max)/2.
- `win_len` changes mid-window take effect at the next START only.

## Test plan
- Window 4, samples 10, 200, 50, 30 back-to-back, `res_ready`=1 → `res_data`=105, `res_seq`=1, one cycle after the 4th accept.
- Same samples with 3 idle cycles between each (`in_valid`=0) → `res_data`=105. `dp_enable` stays 1 and `dp_in`=`hold` during gaps.
- `win_len`=1, samples 77 then 3 → two results, 77 then 3, `res_seq` 1 then 2. `dp_reset`=1 on every accept.
- `win_len`=2, samples 3, 4, 500, 510 with `res_ready`=0 for 5 cycles after first completion:
  - First result 3; `in_ready`=0 while it is pending.
  - After `res_ready` rises, second result 505.
  - No sample is lost.
- `win_len`=4, accept 100, 20, then `run`=0 for 2 cycles, then `run`=1 and samples 8, 9, 10, 11 → single result 9. The aborted window yields nothing.
- `win_len`=0 (CNTW=8), 256 samples 0..255 → one result 127 after the 256th accept. `clear` pulse mid-window → all outputs return to reset values, no result.
